pwm_capture: RTL



---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_capture_if.sv | 34 +++
 rtl/pwm_edge_sync.sv | 77 +++++++
 rtl/pwm_capture.sv | 129 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// The capture FSM state type and the default counter width live here so both
// sides of a loopback agree on sizing.
package pwm_pkg;

    // Default counter width shared with the PWM generator.
    localparam int PWM_WIDTH = 8;

    // Capture FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } pwm_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_capture_if.sv
// Bundle of the pwm_capture control/result signals.
// slave : the capture block (consumes enable and waveform, drives results)
// master: whoever controls the capture block and reads its results
interface pwm_capture_if #(
    parameter int WIDTH = pwm_pkg::PWM_WIDTH
);
    logic             io_en;
    logic             io_in;
    logic [WIDTH-1:0] io_period;
    logic [WIDTH-1:0] io_duty;
    logic             io_valid;
    logic             io_timeout;
    logic [WIDTH-1:0] io_count;

    modport slave (
        input  io_en,
        input  io_in,
        output io_period,
        output io_duty,
        output io_valid,
        output io_timeout,
        output io_count
    );

    modport master (
        output io_en,
        output io_in,
        input  io_period,
        input  io_duty,
        input  io_valid,
        input  io_timeout,
        input  io_count
    );
endinterface : pwm_capture_if

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: metastability synchronizer, optional
// glitch filter and rising-edge detect on the conditioned level.
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN
//   defined   - the level only follows the synchronized input once it has been
//               stable for two consecutive cycles (adds one cycle of latency)
//   undefined - the level is the synchronized input itself
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic f,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic                   fdly_q;     // conditioned level delayed one cycle
    logic                   fdly_d;

    // Shift chain: stage 0 samples the asynchronous pin, each later stage
    // samples the one before it.
    assign sync_d[0] = din;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic s_prev_q;
    logic s_prev_d;

    // Accept a new level only when two consecutive synchronized samples agree;
    // otherwise keep the previously accepted level.
    always_comb begin
        s_prev_d = s;
        f        = (s == s_prev_q) ? s : fdly_q;
    end

    // Previous synchronized sample used by the stability test.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_prev_q <= 1'b0;
        end else begin
            s_prev_q <= s_prev_d;
        end
    end
`else
    // No filtering: the conditioned level is the synchronized input.
    always_comb begin
        f = s;
    end
`endif

    // Delayed level and edge detect.
    always_comb begin
        fdly_d = f;
        rise   = f & ~fdly_q;
    end

    // Synchronizer chain and delayed-level register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            fdly_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            fdly_q <= fdly_d;
        end
    end

endmodule : pwm_edge_sync

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high-time between consecutive rising
// edges of an asynchronous PWM input, one result per period.
// Optional feature macro: PWM_CAPTURE_GLITCH_FILTER_EN (glitch filter inside
// pwm_edge_sync; adds one cycle of latency, leaves 2+ cycle pulses unchanged).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    pwm_capture_if.slave  bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             f;
    logic             rise;

    pwm_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock (clock),
        .reset (reset),
        .din   (bus.io_in),
        .f     (f),
        .rise  (rise)
    );

    // Next-state and datapath: a rise always wins over saturation; saturation
    // without a rise flags a timeout and re-arms without touching the results.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        period_d  = period_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!bus.io_en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hi_d      = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    state_d = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = WIDTH'(1);
                        hi_d    = WIDTH'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hi_d      = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        duty_d    = hi_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = WIDTH'(1);
                        hi_d      = WIDTH'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        hi_d      = '0;
                        state_d   = ARMED;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                        hi_d  = hi_q + WIDTH'(f);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = '0;
                end
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.io_period  = period_q;
    assign bus.io_duty    = duty_q;
    assign bus.io_valid   = valid_q;
    assign bus.io_timeout = timeout_q;
    assign bus.io_count   = cnt_q;

endmodule : pwm_capture
